// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared constants for the branch resolve path: condition codes,
//          FSM state encoding and {l,g,e} flag bit positions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int OW_DEFAULT = 8;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_LT     = 3'd3;
    localparam logic [2:0] COND_GE     = 3'd4;
    localparam logic [2:0] COND_LE     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CMP     = 2'd1;
    localparam state_t ST_RESOLVE = 2'd2;
    localparam state_t ST_HOLD    = 2'd3;

    localparam int FLAG_E = 0;
    localparam int FLAG_G = 1;
    localparam int FLAG_L = 2;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// Module : branch_resolve_unit_if
// Brief  : Request/resolution handshake bundle of the branch resolve unit.
//          Stat counter signals exist only when BRANCH_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
    parameter int DW = 16,
    parameter int OW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [2:0]    cond;
    logic [DW-1:0] pc;
    logic [OW-1:0] offset;
    logic          out_valid;
    logic          out_ready;
    logic          taken;
    logic [DW-1:0] next_pc;
    logic [2:0]    flags;
`ifdef BRANCH_STATS_EN
    logic [15:0]   stat_taken;
    logic [15:0]   stat_not_taken;
`endif

    modport slave (
`ifdef BRANCH_STATS_EN
        output stat_taken,
        output stat_not_taken,
`endif
        input  in_valid,
        output in_ready,
        input  op_a,
        input  op_b,
        input  cond,
        input  pc,
        input  offset,
        output out_valid,
        input  out_ready,
        output taken,
        output next_pc,
        output flags
    );

    modport master (
`ifdef BRANCH_STATS_EN
        input  stat_taken,
        input  stat_not_taken,
`endif
        output in_valid,
        input  in_ready,
        output op_a,
        output op_b,
        output cond,
        output pc,
        output offset,
        input  out_valid,
        output out_ready,
        input  taken,
        input  next_pc,
        input  flags
    );

endinterface

`default_nettype wire

// File: rtl/mag_cmp16.sv
// ============================================================================
// Module : mag_cmp16
// Brief  : Combinational unsigned magnitude compare producing one-hot {l,g,e}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mag_cmp16
    import cpu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [2:0]   flags
);

    always_comb begin
        flags         = 3'b000;
        flags[FLAG_E] = (a == b);
        flags[FLAG_G] = (a >  b);
        flags[FLAG_L] = (a <  b);
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Multi-cycle branch resolver: latch, compare, resolve, hold next-PC
//          until fetch accepts. Define BRANCH_STATS_EN for taken/not-taken
//          saturating counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int OW = OW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);

    localparam logic [DW-1:0] C_ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [2:0]    r_cond;
    logic [DW-1:0] r_pc;
    logic [OW-1:0] r_offset;
    logic [2:0]    r_flags;
    logic          r_taken;
    logic [DW-1:0] r_next_pc;
    logic          r_out_valid;

    logic [2:0]    w_cmp_flags;
    logic          w_taken;
    logic [DW-1:0] w_offset_sext;
    logic [DW-1:0] w_target_pc;
    logic          w_out_hs;

    mag_cmp16 #(
        .W (DW)
    ) u_mag_cmp (
        .a     (r_op_a),
        .b     (r_op_b),
        .flags (w_cmp_flags)
    );

    always_comb begin
        w_taken = 1'b0;
        case (r_cond)
            COND_EQ:     w_taken = r_flags[FLAG_E];
            COND_NE:     w_taken = ~r_flags[FLAG_E];
            COND_GT:     w_taken = r_flags[FLAG_G];
            COND_LT:     w_taken = r_flags[FLAG_L];
            COND_GE:     w_taken = r_flags[FLAG_G] | r_flags[FLAG_E];
            COND_LE:     w_taken = r_flags[FLAG_L] | r_flags[FLAG_E];
            COND_ALWAYS: w_taken = 1'b1;
            default:     w_taken = 1'b0;
        endcase
    end

    // Offset is a signed word offset; the add wraps naturally at DW bits.
    assign w_offset_sext = {{(DW-OW){r_offset[OW-1]}}, r_offset};
    assign w_target_pc   = w_taken ? (r_pc + w_offset_sext) : (r_pc + C_ONE);
    assign w_out_hs      = (r_state == ST_HOLD) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_cond      <= 3'd0;
            r_pc        <= '0;
            r_offset    <= '0;
            r_flags     <= 3'b001;
            r_taken     <= 1'b0;
            r_next_pc   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op_a   <= bus.op_a;
                        r_op_b   <= bus.op_b;
                        r_cond   <= bus.cond;
                        r_pc     <= bus.pc;
                        r_offset <= bus.offset;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_flags <= w_cmp_flags;
                    r_state <= ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    r_taken     <= w_taken;
                    r_next_pc   <= w_target_pc;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.taken     = r_taken;
    assign bus.next_pc   = r_next_pc;
    assign bus.flags     = r_flags;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_stat_taken;
    logic [15:0] r_stat_not_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_taken     <= 16'd0;
            r_stat_not_taken <= 16'd0;
        end else if (w_out_hs) begin
            if (r_taken) begin
                if (r_stat_taken != 16'hFFFF) begin
                    r_stat_taken <= r_stat_taken + 16'd1;
                end
            end else begin
                if (r_stat_not_taken != 16'hFFFF) begin
                    r_stat_not_taken <= r_stat_not_taken + 16'd1;
                end
            end
        end
    end

    assign bus.stat_taken     = r_stat_taken;
    assign bus.stat_not_taken = r_stat_not_taken;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_out_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Self-checking bench for branch_resolve_unit (directed table,
//          backpressure/reset sequences, randomized against a reference model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    branch_resolve_unit_if #(.DW(16), .OW(8)) bus ();

    branch_resolve_unit #(.DW(16), .OW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_st_taken = 0;
    int exp_st_not_taken = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  c;
        logic [15:0] pc;
        logic [7:0]  off;
        logic        t;
        logic [15:0] np;
        logic [2:0]  fl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: condition evaluated straight from the operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] c, input logic [15:0] pc,
                                  input logic [7:0] off, output logic t,
                                  output logic [15:0] np, output logic [2:0] fl);
        int so;
        int sum;
        fl = (a < b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
        case (c)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd2: t = (a > b);
            3'd3: t = (a < b);
            3'd4: t = (a >= b);
            3'd5: t = (a <= b);
            3'd6: t = 1'b1;
            default: t = 1'b0;
        endcase
        so  = int'($signed(off));
        sum = t ? (int'(pc) + so) : (int'(pc) + 1);
        np  = 16'(sum);
    endfunction

    // Called at posedge+1 with the unit idle; returns at posedge+1 after the handshake.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                           input logic [15:0] pc, input logic [7:0] off,
                           input int hold_cycles, input bit junk,
                           output logic t, output logic [15:0] np, output logic [2:0] fl);
        int lat;
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.op_a = a; bus.op_b = b; bus.cond = c; bus.pc = pc; bus.offset = off;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 3);
        t = bus.taken; np = bus.next_pc; fl = bus.flags;
        if (junk) begin
            bus.op_a = 16'h0009; bus.op_b = 16'h0001; bus.cond = COND_NEVER;
            bus.pc = 16'hAAAA; bus.offset = 8'h00; bus.in_valid = 1'b1;
        end
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", {13'd0, bus.out_valid, bus.in_ready, bus.taken, bus.next_pc},
                {13'd0, 1'b1, 1'b0, t, np});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("handshake_done", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    logic        got_t;
    logic [15:0] got_np;
    logic [2:0]  got_fl;
    logic        e_t;
    logic [15:0] e_np;
    logic [2:0]  e_fl;
    logic [15:0] ra, rb, rpc;
    logic [2:0]  rc;
    logic [7:0]  roff;

    task automatic chk_stats();
`ifdef BRANCH_STATS_EN
        chk("stat_taken", {16'd0, bus.stat_taken}, exp_st_taken);
        chk("stat_not_taken", {16'd0, bus.stat_not_taken}, exp_st_not_taken);
`endif
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, COND_EQ,     16'h0100, 8'h10, 1'b1, 16'h0110, 3'b001};
        vecs[1] = '{16'h8000, 16'h7FFF, COND_LT,     16'h0200, 8'h05, 1'b0, 16'h0201, 3'b010};
        vecs[2] = '{16'h8000, 16'h7FFF, COND_GE,     16'h0200, 8'h05, 1'b1, 16'h0205, 3'b010};
        vecs[3] = '{16'h0000, 16'h0000, COND_NEVER,  16'hFFFF, 8'h00, 1'b0, 16'h0000, 3'b001};
        vecs[4] = '{16'h0001, 16'h0002, COND_ALWAYS, 16'h0002, 8'hFC, 1'b1, 16'hFFFE, 3'b100};
        vecs[5] = '{16'h0005, 16'h0009, COND_LE,     16'h1000, 8'h80, 1'b1, 16'h0F80, 3'b100};
        vecs[6] = '{16'h0009, 16'h0005, COND_NE,     16'h0010, 8'h7F, 1'b1, 16'h008F, 3'b010};
        vecs[7] = '{16'h0003, 16'h0003, COND_GT,     16'h0020, 8'h01, 1'b0, 16'h0021, 3'b001};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.cond = '0; bus.pc = '0; bus.offset = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_flags", {29'd0, bus.flags}, 32'd1);
        chk("rst_taken_npc", {15'd0, bus.taken, bus.next_pc}, 32'd0);
        chk_stats();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while nothing is pending must not disturb the idle unit
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_out_ready_ignored", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        end
        bus.out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].pc, vecs[i].off, 0, 1'b0,
                    got_t, got_np, got_fl);
            chk($sformatf("vec%0d_taken", i), {31'd0, got_t}, {31'd0, vecs[i].t});
            chk($sformatf("vec%0d_next_pc", i), {16'd0, got_np}, {16'd0, vecs[i].np});
            chk($sformatf("vec%0d_flags", i), {29'd0, got_fl}, {29'd0, vecs[i].fl});
            if (vecs[i].t) exp_st_taken++; else exp_st_not_taken++;
            chk($sformatf("vec%0d_flags_persist", i), {29'd0, bus.flags}, {29'd0, vecs[i].fl});
        end
        chk_stats();

        // Backpressure with a competing request that must be ignored
        run_txn(16'h0001, 16'h0002, COND_LT, 16'h0300, 8'h20, 5, 1'b1, got_t, got_np, got_fl);
        chk("bp_taken", {31'd0, got_t}, 32'd1);
        chk("bp_next_pc", {16'd0, got_np}, 32'h0320);
        exp_st_taken++;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_after_idle", {27'd0, bus.out_valid, bus.in_ready, bus.flags}, {27'd0, 2'b01, 3'b100});
        end
        chk_stats();

        // Reset while in CMP discards the request
        bus.op_a = 16'h8000; bus.op_b = 16'h0001; bus.cond = COND_ALWAYS;
        bus.pc = 16'h4000; bus.offset = 8'h04; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("cmp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_state", {26'd0, bus.out_valid, bus.in_ready, bus.taken, bus.flags},
            {26'd0, 1'b0, 1'b1, 1'b0, 3'b001});
        chk("midrst_next_pc", {16'd0, bus.next_pc}, 32'd0);
        exp_st_taken = 0; exp_st_not_taken = 0;
        chk_stats();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_output", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rc   = 3'($urandom_range(0, 7));
            rpc  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            roff = 8'($urandom);
            model(ra, rb, rc, rpc, roff, e_t, e_np, e_fl);
            run_txn(ra, rb, rc, rpc, roff, $urandom_range(0, 2), 1'b0, got_t, got_np, got_fl);
            chk("rnd_taken", {31'd0, got_t}, {31'd0, e_t});
            chk("rnd_next_pc", {16'd0, got_np}, {16'd0, e_np});
            chk("rnd_flags", {29'd0, got_fl}, {29'd0, e_fl});
            if (e_t) exp_st_taken++; else exp_st_not_taken++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        chk_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
